nibble_addsub: RTL and testbench
================================

# nibble_addsub

Nibble-serial add/subtract unit that sits directly downstream of the conditional inverter in the ALU datapath. It takes operand A and the inverter output (B or ~B), using the inverter's `invert` control as carry-in. It produces an 8-bit sum plus carry, zero, negative and overflow flags over WIDTH/DIGIT clock cycles. Serial processing keeps adder area to one DIGIT-wide slice; a start/busy/done handshake paces the issue logic.

## Interface
- `WIDTH`, default 8: operand and result width; must be a multiple of DIGIT.
- `DIGIT`, default 4: bits added per cycle.
- `clk`  in  1  rising-edge clock; the block's only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a new operation; sampled only in IDLE.
- `a`  in  WIDTH  operand A.
- `b_inv`  in  WIDTH  operand B after the conditional inverter (~B when subtracting).
- `cin`  in  1  carry-in; wired to the inverter's `invert` (1 = subtract).
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse: result and flags updated.
- `sum`  out  WIDTH  result; holds until the next completion.
- `cout`  out  1  final carry (for subtract, 1 = no borrow).
- `zero`  out  1  sum == 0.
- `neg`  out  1  sum[WIDTH-1].
- `ovf`  out  1  signed overflow.

## Operation
- States: IDLE, RUN, DONE.
- IDLE with `start`=1 at an edge:
  - latch `a` and `b_inv` into shift registers;
  - carry reg ← `cin`; digit count ← 0;
  - latch sign bits a[MSB] and b_inv[MSB] for the overflow check;
  - go to RUN.
- RUN, each edge:
  - add the low DIGIT bits of the A and B shift registers plus the carry reg;
  - shift the digit result in from the top of the sum shift register;
  - shift both operand registers right by DIGIT;
  - update the carry reg; increment the count.
- RUN exit: on the edge that processes digit WIDTH/DIGIT−1, go to DONE and load the output registers:
  - `sum`, `cout`;
  - `zero` = (sum == 0);
  - `neg` = sum MSB;
  - `ovf` = (a_msb == b_msb) && (sum_msb ≠ a_msb).
- DONE: `done`=1 for exactly this cycle, then unconditionally return to IDLE.
- `start` in RUN or DONE is ignored; it is not queued.
- Operands may change after the start edge without affecting the result.
- Arithmetic is modulo 2^WIDTH; carry out of the MSB goes to `cout` only.

## Timing
- Reset (asynchronous, any state, including mid-RUN):
  - state ← IDLE;
  - `busy`, `done`, `sum`, `cout`, `zero`, `neg`, `ovf` all ← 0;
  - the internal shift registers and count ← 0.
- After `rst_n` deasserts, the first `start` is accepted at the next rising edge.
- Start accepted at edge E0: `busy`=1 after E0.
- Digits are processed at E1..EN, where N = WIDTH/DIGIT (N = 2 by default).
- `done`=1 and new results are visible after EN.
- At EN+1: `done`=0 and `busy`=0.
- Earliest next accepted start is EN+2, giving a throughput of one operation per N+2 cycles.
- Outputs are registered; nothing combinational runs from inputs to outputs.

## Structure
- Package `alu_pkg`:
  - state enum {IDLE, RUN, DONE};
  - default WIDTH and DIGIT localparams;
  - count width = $clog2(WIDTH/DIGIT).
- Sub-module `digit_adder`: a combinational DIGIT-bit ripple adder with ports a, b, ci, s, co, instantiated once.

## Test plan
- a=0x35, b_inv=0x4A, cin=0 → after N edges: sum=0x7F; cout, zero, neg, ovf = 0; `done` pulse exactly 1 cycle.
- a=0x10, b=0x10 subtract (b_inv=0xEF, cin=1) → sum=0x00, zero=1, cout=1, ovf=0.
- a=0x7F, b_inv=0x01, cin=0 → sum=0x80, neg=1, ovf=1, cout=0.
- a=0xFF, b_inv=0x01, cin=0 → sum=0x00, cout=1, zero=1, ovf=0.
- `start` held high continuously with new operands every cycle → operations are accepted only in IDLE, one per N+2 cycles; each result matches the operands sampled at its own start edge.
- `rst_n` pulsed low during RUN after the first digit → all outputs 0 and `busy`=0 immediately (asynchronously); no `done` pulse; the next start completes correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and defaults for the nibble-serial add/subtract slice.
package alu_pkg;

  // Sequencer states: waiting, adding digits, one-cycle completion.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIGIT = 4;
  localparam int DEF_CNT_W = $clog2(DEF_WIDTH / DEF_DIGIT);

  // Digit-counter width for n digits; never narrower than one bit so a
  // single-digit configuration still elaborates a legal counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// DIGIT-bit combinational ripple-carry adder: the only adder slice in the unit.
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  // Ripple the carry from bit 0 upwards through full-adder cells.
  always_comb begin
    logic c;
    c  = ci;
    s  = '0;
    for (int i = 0; i < DIGIT; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/nibble_addsub.sv
// Nibble-serial add/subtract unit. Operand A and the conditionally inverted
// operand B are captured on start, summed DIGIT bits per cycle through one
// digit_adder, and the registered result plus carry/zero/neg/ovf flags are
// published together with a one-cycle done pulse.
module nibble_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b_inv,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  state_t             state_r;
  state_t             next_state_s;
  logic [WIDTH-1:0]   a_sh_r;
  logic [WIDTH-1:0]   b_sh_r;
  logic [WIDTH-1:0]   sum_sh_r;
  logic [WIDTH-1:0]   sum_next_s;
  logic               carry_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               a_msb_r;
  logic               b_msb_r;
  logic [DIGIT-1:0]   dsum_s;
  logic               dco_s;
  logic               last_s;
  logic [WIDTH-1:0]   sum_r;
  logic               cout_r;
  logic               zero_r;
  logic               neg_r;
  logic               ovf_r;

  digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
    .a  (a_sh_r[DIGIT-1:0]),
    .b  (b_sh_r[DIGIT-1:0]),
    .ci (carry_r),
    .s  (dsum_s),
    .co (dco_s)
  );

  // New digits enter at the top so after N steps the low digit sits at bit 0.
  generate
    if (WIDTH > DIGIT) begin : g_multi_digit
      assign sum_next_s = {dsum_s, sum_sh_r[WIDTH-1:DIGIT]};
    end else begin : g_single_digit
      assign sum_next_s = dsum_s;
    end
  endgenerate

  assign last_s = (state_r == RUN) && (cnt_r == LAST_CNT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic: start only honoured in IDLE, DONE always lasts one cycle.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = RUN;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == LAST_CNT) begin
          next_state_s = DONE;
        end else begin
          next_state_s = RUN;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Operand capture on start, then one digit per cycle while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_r   <= '0;
      b_sh_r   <= '0;
      sum_sh_r <= '0;
      carry_r  <= 1'b0;
      cnt_r    <= '0;
      a_msb_r  <= 1'b0;
      b_msb_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_sh_r  <= a;
            b_sh_r  <= b_inv;
            carry_r <= cin;
            cnt_r   <= '0;
            a_msb_r <= a[WIDTH-1];
            b_msb_r <= b_inv[WIDTH-1];
          end
        end
        RUN: begin
          sum_sh_r <= sum_next_s;
          a_sh_r   <= a_sh_r >> DIGIT;
          b_sh_r   <= b_sh_r >> DIGIT;
          carry_r  <= dco_s;
          cnt_r    <= cnt_r + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Result and flags load only when the final digit is processed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r  <= '0;
      cout_r <= 1'b0;
      zero_r <= 1'b0;
      neg_r  <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (last_s) begin
      sum_r  <= sum_next_s;
      cout_r <= dco_s;
      zero_r <= (sum_next_s == '0);
      neg_r  <= sum_next_s[WIDTH-1];
      ovf_r  <= (a_msb_r == b_msb_r) && (sum_next_s[WIDTH-1] != a_msb_r);
    end
  end

  // busy/done decode the state register only, so no input reaches them.
  assign busy = (state_r != IDLE);
  assign done = (state_r == DONE);
  assign sum  = sum_r;
  assign cout = cout_r;
  assign zero = zero_r;
  assign neg  = neg_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_nibble_addsub.sv
// Self-checking bench for nibble_addsub (WIDTH=8, DIGIT=4, N=2).
module tb_nibble_addsub;

  localparam int N = 2;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b_inv;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
  logic       zero;
  logic       neg;
  logic       ovf;

  int checks;
  int failures;

  nibble_addsub #(.WIDTH(8), .DIGIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b_inv (b_inv),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .zero  (zero),
    .neg   (neg),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: full-precision arithmetic, returns {cout, zero, neg, ovf, sum}.
  function automatic logic [11:0] model(input logic [7:0] ma, input logic [7:0] mb, input logic mc);
    int u;
    int sa;
    int sb;
    int ss;
    logic [7:0] s;
    logic ov;
    u  = int'(ma) + int'(mb) + int'(mc);
    sa = ma[7] ? int'(ma) - 256 : int'(ma);
    sb = mb[7] ? int'(mb) - 256 : int'(mb);
    ss = sa + sb + int'(mc);
    s  = u[7:0];
    ov = (ss > 127) || (ss < -128);
    return {(u > 255), (s == 8'h00), s[7], ov, s};
  endfunction

  // Issue one operation and collect what the DUT shows (stimulus only).
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        output int lat, output logic busy0, output logic [11:0] res,
                        output logic done_after, output logic busy_after);
    @(negedge clk);
    a = ta; b_inv = tb; cin = tc; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 8'($urandom); b_inv = 8'($urandom); cin = 1'($urandom);
    @(negedge clk);
    busy0 = busy;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
    res = {cout, zero, neg, ovf, sum};
    @(negedge clk);
    done_after = done;
    busy_after = busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = 8'h00; b_inv = 8'h00; cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, sum, cout, zero, neg, ovf} !== 14'h0000) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0000", {busy, done, sum, cout, zero, neg, ovf});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [7:0]  ta [4] = '{8'h35, 8'h10, 8'h7F, 8'hFF};
    logic [7:0]  tb [4] = '{8'h4A, 8'hEF, 8'h01, 8'h01};
    logic        tc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [11:0] te [4] = '{{4'b0000, 8'h7F}, {4'b1100, 8'h00}, {4'b0011, 8'h80}, {4'b1100, 8'h00}};
    int lat;
    logic b0, da, ba;
    logic [11:0] res;
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], tb[i], tc[i], lat, b0, res, da, ba);
      checks++;
      if (res !== te[i]) begin
        failures++;
        $display("FAIL directed_%0d result {co,z,n,o,sum} got=%h want=%h", i, res, te[i]);
      end
      checks++;
      if (lat != N || b0 !== 1'b1) begin
        failures++;
        $display("FAIL directed_%0d timing lat=%0d busy0=%b want lat=%0d busy0=1", i, lat, b0, N);
      end
      checks++;
      if (da !== 1'b0 || ba !== 1'b0) begin
        failures++;
        $display("FAIL directed_%0d done_pulse done=%b busy=%b want 0 0", i, da, ba);
      end
    end
  endtask

  task automatic test_random();
    int lat;
    logic b0, da, ba, tc;
    logic [7:0] ta, tb;
    logic [11:0] res, exp_r;
    for (int i = 0; i < 30; i++) begin
      ta = 8'($urandom); tb = 8'($urandom); tc = 1'($urandom);
      exp_r = model(ta, tb, tc);
      run_op(ta, tb, tc, lat, b0, res, da, ba);
      checks++;
      if (res !== exp_r || lat != N || da !== 1'b0 || ba !== 1'b0) begin
        failures++;
        $display("FAIL random_%0d a=%h b=%h c=%b got=%h lat=%0d d=%b b=%b want=%h lat=%0d",
                 i, ta, tb, tc, res, lat, da, ba, exp_r, N);
      end
    end
  endtask

  task automatic test_back_to_back();
    localparam int NC = 5 * (N + 2);
    logic [7:0] qa [NC];
    logic [7:0] qb [NC];
    logic       qc [NC];
    logic [11:0] exp_r;
    logic exp_done;
    int j;
    @(negedge clk);
    for (int i = 0; i < NC; i++) begin
      qa[i] = 8'($urandom); qb[i] = 8'($urandom); qc[i] = 1'($urandom);
      a = qa[i]; b_inv = qb[i]; cin = qc[i]; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      j = i - N;
      exp_done = (j >= 0) && (j % (N + 2) == 0);
      checks++;
      if (done !== exp_done) begin
        failures++;
        $display("FAIL b2b_done edge=%0d got=%b want=%b", i, done, exp_done);
      end
      if (done === 1'b1 && exp_done) begin
        exp_r = model(qa[j], qb[j], qc[j]);
        checks++;
        if ({cout, zero, neg, ovf, sum} !== exp_r) begin
          failures++;
          $display("FAIL b2b_result edge=%0d got=%h want=%h", i, {cout, zero, neg, ovf, sum}, exp_r);
        end
      end
    end
    start = 1'b0;
    repeat (N + 2) @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int lat;
    logic b0, da, ba;
    logic [11:0] res, exp_r;
    logic saw_done;
    // Leave non-zero result and flags so the reset clearing is visible.
    run_op(8'h7F, 8'h01, 1'b0, lat, b0, res, da, ba);
    @(negedge clk);
    a = 8'h12; b_inv = 8'h34; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, sum, cout, zero, neg, ovf} !== 14'h0000) begin
      failures++;
      $display("FAIL midrun_async_clear got=%h want=0000", {busy, done, sum, cout, zero, neg, ovf});
    end
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      failures++;
      $display("FAIL midrun_no_done got=activity want=idle");
    end
    exp_r = model(8'hA5, 8'hC3, 1'b1);
    run_op(8'hA5, 8'hC3, 1'b1, lat, b0, res, da, ba);
    checks++;
    if (res !== exp_r || lat != N) begin
      failures++;
      $display("FAIL midrun_recovery got=%h lat=%0d want=%h lat=%0d", res, lat, exp_r, N);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
